// File: rtl/mac_table_pkg.sv
// Shared definitions for the MAC forwarding-table arbiter: entry layout and FSM states.
package mac_table_pkg;

    localparam int unsigned MAC_W    = 48;
    localparam int unsigned PORT_LSB = 0;

    // Entry layout, MSB first: {valid, hit, mac[47:0], port}. Positions depend on the port width.
    function automatic int unsigned mac_lsb(int unsigned port_w);
        return PORT_LSB + port_w;
    endfunction

    function automatic int unsigned hit_bit(int unsigned port_w);
        return mac_lsb(port_w) + MAC_W;
    endfunction

    function automatic int unsigned valid_bit(int unsigned port_w);
        return hit_bit(port_w) + 1;
    endfunction

    function automatic int unsigned entry_width(int unsigned port_w);
        return valid_bit(port_w) + 1;
    endfunction

    // Port-width-independent upper part of an entry
    typedef struct packed {
        logic             valid;
        logic             hit;
        logic [MAC_W-1:0] mac;
    } entry_hdr_t;

    typedef enum logic [2:0] {
        StIdle,
        StLkWait,
        StLkCmp,
        StLnWait,
        StLnCmp,
        StAgWait,
        StAgCmp
    } arb_state_e;

endpackage

// File: rtl/mac_age_ticker.sv
// Aging timebase: prescaler, pending-step flag with overrun detection, and sweep pointer.
module mac_age_ticker #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned AGE_DIV    = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  age_en,
    input  logic                  step_done,
    output logic                  age_pending,
    output logic                  age_overrun,
    output logic [ADDR_WIDTH-1:0] sweep_ptr
);

    localparam int unsigned      CNT_W   = $clog2(AGE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AGE_DIV - 1);

    logic [CNT_W-1:0]      presc_q, presc_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  tick;

    // Next-state: prescaler wrap produces a tick; a tick on a still-pending step is dropped
    always_comb begin
        tick      = age_en && (presc_q == CNT_MAX);
        presc_d   = presc_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        ptr_d     = ptr_q;
        if (age_en) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
        end
        if (step_done) begin
            pending_d = 1'b0;
            ptr_d     = ptr_q + ADDR_WIDTH'(1);
        end
        // A step finishing this cycle frees the slot, so the new tick is accepted
        if (tick) begin
            if (pending_q && !step_done) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
        end
    end

    assign age_pending = pending_q;
    assign age_overrun = overrun_q;
    assign sweep_ptr   = ptr_q;

endmodule

// File: rtl/mac_table_arbiter.sv
// Owns the single-port MAC table RAM: arbitrates lookup, learn and aging accesses,
// performs lookup compare, learn read-modify-write and age-bit maintenance.
module mac_table_arbiter
    import mac_table_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned PORT_WIDTH = 16,
    parameter int unsigned AGE_DIV    = 1000000,
    localparam int unsigned EW        = entry_width(PORT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lk_req,
    input  logic [ADDR_WIDTH-1:0] lk_hash,
    input  logic [MAC_W-1:0]      lk_mac,
    output logic                  lk_ack,
    output logic                  lk_hit,
    output logic [PORT_WIDTH-1:0] lk_port,
    input  logic                  ln_req,
    input  logic [ADDR_WIDTH-1:0] ln_hash,
    input  logic [MAC_W-1:0]      ln_mac,
    input  logic [PORT_WIDTH-1:0] ln_port,
    output logic                  ln_ack,
    output logic                  ln_new,
    input  logic                  age_en,
    output logic                  aged_out,
    output logic                  age_overrun,
    output logic [ADDR_WIDTH-1:0] tbl_addr,
    output logic                  tbl_rd,
    output logic                  tbl_wr,
    output logic [EW-1:0]         tbl_wdata,
    input  logic [EW-1:0]         tbl_rdata
);

    localparam int unsigned MAC_LSB = mac_lsb(PORT_WIDTH);

    arb_state_e            state;
    logic                  last_lk;
    logic                  age_pending;
    logic                  step_done;
    logic [ADDR_WIDTH-1:0] sweep_ptr;
    entry_hdr_t            rd_hdr;
    logic [PORT_WIDTH-1:0] rd_port;
    logic                  lk_live, ln_live;
    logic                  grant_lk, grant_ln, grant_ag;
    logic                  lk_match, ln_same;

    mac_age_ticker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AGE_DIV    (AGE_DIV)
    ) u_ticker (
        .clk         (clk),
        .reset       (reset),
        .age_en      (age_en),
        .step_done   (step_done),
        .age_pending (age_pending),
        .age_overrun (age_overrun),
        .sweep_ptr   (sweep_ptr)
    );

    assign rd_hdr    = entry_hdr_t'(tbl_rdata[EW-1:MAC_LSB]);
    assign rd_port   = tbl_rdata[PORT_LSB +: PORT_WIDTH];
    assign step_done = (state == StAgCmp);

    // Grant and compare decisions
    always_comb begin
        // A request still high in its own ack cycle is the finished one, not a new one
        lk_live  = lk_req && !lk_ack;
        ln_live  = ln_req && !ln_ack;
        grant_lk = lk_live && (!ln_live || !last_lk);
        grant_ln = ln_live && (!lk_live || last_lk);
        // Aging yields to any raised request line, including one just acked
        grant_ag = age_pending && !lk_req && !ln_req;
        lk_match = rd_hdr.valid && (rd_hdr.mac == lk_mac);
        ln_same  = rd_hdr.valid && rd_hdr.hit && (rd_hdr.mac == ln_mac) && (rd_port == ln_port);
    end

    // Access sequencer with registered RAM strobes and result pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            last_lk   <= 1'b0;
            tbl_addr  <= '0;
            tbl_rd    <= 1'b0;
            tbl_wr    <= 1'b0;
            tbl_wdata <= '0;
            lk_ack    <= 1'b0;
            lk_hit    <= 1'b0;
            lk_port   <= '0;
            ln_ack    <= 1'b0;
            ln_new    <= 1'b0;
            aged_out  <= 1'b0;
        end else begin
            tbl_rd   <= 1'b0;
            tbl_wr   <= 1'b0;
            lk_ack   <= 1'b0;
            lk_hit   <= 1'b0;
            lk_port  <= '0;
            ln_ack   <= 1'b0;
            ln_new   <= 1'b0;
            aged_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_lk) begin
                        state    <= StLkWait;
                        tbl_rd   <= 1'b1;
                        tbl_addr <= lk_hash;
                        last_lk  <= 1'b1;
                    end else if (grant_ln) begin
                        state    <= StLnWait;
                        tbl_rd   <= 1'b1;
                        tbl_addr <= ln_hash;
                        last_lk  <= 1'b0;
                    end else if (grant_ag) begin
                        state    <= StAgWait;
                        tbl_rd   <= 1'b1;
                        tbl_addr <= sweep_ptr;
                    end
                end
                StLkWait: state <= StLkCmp;
                StLkCmp: begin
                    lk_ack  <= 1'b1;
                    lk_hit  <= lk_match;
                    lk_port <= lk_match ? rd_port : '0;
                    state   <= StIdle;
                end
                StLnWait: state <= StLnCmp;
                StLnCmp: begin
                    ln_ack <= 1'b1;
                    if (!ln_same) begin
                        tbl_wr    <= 1'b1;
                        tbl_wdata <= {1'b1, 1'b1, ln_mac, ln_port};
                        ln_new    <= 1'b1;
                    end
                    state <= StIdle;
                end
                StAgWait: state <= StAgCmp;
                StAgCmp: begin
                    // Referenced entry loses its hit bit; an unreferenced one is evicted
                    if (rd_hdr.valid) begin
                        tbl_wr    <= 1'b1;
                        tbl_wdata <= {rd_hdr.hit, 1'b0, rd_hdr.mac, rd_port};
                        aged_out  <= !rd_hdr.hit;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_table_arbiter.sv
// Randomized self-checking bench for mac_table_arbiter with a behavioural table RAM and
// a reference table model kept as plain per-entry arrays.
module tb_mac_table_arbiter;

    localparam int AW  = 3;
    localparam int PW  = 8;
    localparam int DIV = 4;
    localparam int EW  = 2 + 48 + PW;
    localparam int NE  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          lk_req = 1'b0;
    logic [AW-1:0] lk_hash = '0;
    logic [47:0]   lk_mac = '0;
    logic          lk_ack, lk_hit;
    logic [PW-1:0] lk_port;
    logic          ln_req = 1'b0;
    logic [AW-1:0] ln_hash = '0;
    logic [47:0]   ln_mac = '0;
    logic [PW-1:0] ln_port = '0;
    logic          ln_ack, ln_new;
    logic          age_en = 1'b0;
    logic          aged_out, age_overrun;
    logic [AW-1:0] tbl_addr;
    logic          tbl_rd, tbl_wr;
    logic [EW-1:0] tbl_wdata;
    logic [EW-1:0] tbl_rdata = '0;

    mac_table_arbiter #(
        .ADDR_WIDTH (AW),
        .PORT_WIDTH (PW),
        .AGE_DIV    (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lk_req      (lk_req),
        .lk_hash     (lk_hash),
        .lk_mac      (lk_mac),
        .lk_ack      (lk_ack),
        .lk_hit      (lk_hit),
        .lk_port     (lk_port),
        .ln_req      (ln_req),
        .ln_hash     (ln_hash),
        .ln_mac      (ln_mac),
        .ln_port     (ln_port),
        .ln_ack      (ln_ack),
        .ln_new      (ln_new),
        .age_en      (age_en),
        .aged_out    (aged_out),
        .age_overrun (age_overrun),
        .tbl_addr    (tbl_addr),
        .tbl_rd      (tbl_rd),
        .tbl_wr      (tbl_wr),
        .tbl_wdata   (tbl_wdata),
        .tbl_rdata   (tbl_rdata)
    );

    always #5 clk = ~clk;

    // Table RAM and bus activity monitor
    logic [EW-1:0] mem [NE] = '{default: '0};
    logic          clr_mem = 1'b0;
    logic          mon_age = 1'b0;
    int            wr_count = 0, rd_count = 0, aged_count = 0, ovr_count = 0, both_seen = 0;
    logic [EW-1:0] last_wdata = '0;
    logic [AW-1:0] last_waddr = '0;
    logic [AW-1:0] age_addr_log [64];
    int            age_n = 0;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < NE; i++) mem[i] <= '0;
        end else if (tbl_wr) begin
            mem[tbl_addr] <= tbl_wdata;
        end
        if (tbl_rd) begin
            tbl_rdata <= mem[tbl_addr];
            rd_count  <= rd_count + 1;
        end
        if (tbl_wr) begin
            wr_count   <= wr_count + 1;
            last_wdata <= tbl_wdata;
            last_waddr <= tbl_addr;
        end
        if (tbl_rd && tbl_wr) both_seen <= both_seen + 1;
        if (aged_out) aged_count <= aged_count + 1;
        if (age_overrun) ovr_count <= ovr_count + 1;
        if (mon_age && tbl_rd && age_n < 64) begin
            age_addr_log[age_n] <= tbl_addr;
            age_n <= age_n + 1;
        end
    end

    // Reference table
    bit            ref_valid [NE];
    bit            ref_hit   [NE];
    logic [47:0]   ref_mac   [NE];
    logic [PW-1:0] ref_port  [NE];
    int            ptr_m = 0, exp_aged = 0;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ref_entry(input int a);
        return {ref_valid[a], ref_hit[a], ref_mac[a], ref_port[a]};
    endfunction

    function automatic logic [47:0] mk_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Aging rule: referenced -> unreferenced, unreferenced -> removed
    task automatic age_model(input int steps);
        for (int s = 0; s < steps; s++) begin
            if (ref_valid[ptr_m] && ref_hit[ptr_m]) begin
                ref_hit[ptr_m] = 1'b0;
            end else if (ref_valid[ptr_m]) begin
                ref_valid[ptr_m] = 1'b0;
                exp_aged++;
            end
            ptr_m = (ptr_m + 1) % NE;
        end
    endtask

    task automatic do_lookup(input logic [AW-1:0] h, input logic [47:0] m);
        int lat = 0;
        bit exp_hit;
        lk_hash = h;
        lk_mac  = m;
        lk_req  = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (lk_ack) lat = i;
        end
        lk_req  = 1'b0;
        exp_hit = ref_valid[h] && (ref_mac[h] == m);
        check("lk_latency", lat, 3);
        check("lk_hit", lk_hit, exp_hit);
        check("lk_port", lk_port, exp_hit ? ref_port[h] : '0);
        tick();
    endtask

    task automatic do_learn(input logic [AW-1:0] h, input logic [47:0] m, input logic [PW-1:0] p);
        int lat = 0;
        int wr0 = wr_count;
        bit exp_new;
        ln_hash = h;
        ln_mac  = m;
        ln_port = p;
        ln_req  = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (ln_ack) lat = i;
        end
        ln_req  = 1'b0;
        exp_new = !(ref_valid[h] && ref_hit[h] && ref_mac[h] == m && ref_port[h] == p);
        check("ln_latency", lat, 3);
        check("ln_new", ln_new, exp_new);
        tick();
        check("ln_wr_count", wr_count - wr0, exp_new);
        if (exp_new) begin
            check("ln_wdata", last_wdata, {2'b11, m, p});
            check("ln_waddr", last_waddr, h);
        end
        ref_valid[h] = 1'b1;
        ref_hit[h]   = 1'b1;
        ref_mac[h]   = m;
        ref_port[h]  = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] pool [4];
        logic [47:0] mac_a, mac_x;
        int          order [$];
        int          rd0, ov0, ag0, base, nack, errs, wr0, acks_seen;
        bit          seen;
        bit          exp_hit, exp_new;

        for (int i = 0; i < NE; i++) begin
            ref_valid[i] = 1'b0;
            ref_hit[i]   = 1'b0;
            ref_mac[i]   = '0;
            ref_port[i]  = '0;
        end

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl_outs", {lk_ack, lk_hit, lk_port, ln_ack, ln_new, aged_out, age_overrun,
                                tbl_addr, tbl_rd, tbl_wr}, '0);
        check("rst_wdata", tbl_wdata, '0);
        reset = 1'b1;
        tick();
        tick();

        // Directed learn / lookup / refresh / move
        mac_a = 48'h001122334455;
        do_learn(3'h5, mac_a, 8'd3);
        do_lookup(3'h5, mac_a);
        do_learn(3'h5, mac_a, 8'd3);
        do_learn(3'h5, mac_a, 8'd7);
        do_lookup(3'h5, mac_a);
        do_lookup(3'h5, mac_a ^ 48'h1);

        // Randomized traffic over a small MAC pool to force hits, moves and collisions
        for (int i = 0; i < 4; i++) pool[i] = mk_mac();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_learn(AW'($urandom_range(0, NE - 1)), pool[$urandom_range(0, 3)],
                         PW'($urandom_range(1, 2)));
            end else begin
                do_lookup(AW'($urandom_range(0, NE - 1)), pool[$urandom_range(0, 3)]);
            end
        end

        // Both requesters held: grants must alternate
        lk_hash = 3'h2;
        lk_mac  = pool[0];
        ln_hash = 3'h2;
        ln_mac  = pool[0];
        ln_port = 8'd9;
        lk_req  = 1'b1;
        ln_req  = 1'b1;
        for (int i = 0; i < 100 && order.size() < 8; i++) begin
            tick();
            if (lk_ack) begin
                order.push_back(0);
                exp_hit = ref_valid[2] && ref_mac[2] == pool[0];
                check("arb_lk_hit", lk_hit, exp_hit);
            end
            if (ln_ack) begin
                order.push_back(1);
                exp_new = !(ref_valid[2] && ref_hit[2] && ref_mac[2] == pool[0] && ref_port[2] == 8'd9);
                check("arb_ln_new", ln_new, exp_new);
                ref_valid[2] = 1'b1;
                ref_hit[2]   = 1'b1;
                ref_mac[2]   = pool[0];
                ref_port[2]  = 8'd9;
            end
        end
        lk_req = 1'b0;
        ln_req = 1'b0;
        tick();
        check("arb_count", order.size(), 8);
        errs = 0;
        for (int i = 1; i < order.size(); i++) if (order[i] == order[i-1]) errs++;
        check("arb_alternate", errs, 0);
        do_lookup(3'h2, pool[0]);

        // Reset while the learn sits in its compare cycle
        mac_x   = mk_mac();
        wr0     = wr_count;
        ln_hash = 3'h6;
        ln_mac  = mac_x;
        ln_port = 8'd5;
        ln_req  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        ln_req = 1'b0;
        check("midrst_ctrl_outs", {lk_ack, lk_hit, lk_port, ln_ack, ln_new, aged_out, age_overrun,
                                   tbl_addr, tbl_rd, tbl_wr}, '0);
        check("midrst_wdata", tbl_wdata, '0);
        tick();
        tick();
        reset = 1'b1;
        acks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ln_ack) acks_seen++;
        end
        check("midrst_no_ack", acks_seen, 0);
        check("midrst_no_wr", wr_count - wr0, 0);
        do_lookup(3'h6, mac_x);
        do_lookup(3'h5, mac_a);

        // Aging: one learned entry in an otherwise empty table, no traffic
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        for (int i = 0; i < NE; i++) begin
            ref_valid[i] = 1'b0;
            ref_hit[i]   = 1'b0;
            ref_mac[i]   = '0;
            ref_port[i]  = '0;
        end
        do_learn(3'h5, mac_a, 8'd4);
        ptr_m    = 0;
        exp_aged = 0;
        ag0      = aged_count;
        base     = age_n;
        mon_age  = 1'b1;
        age_en   = 1'b1;
        for (int i = 0; i < 300 && age_n < base + 9; i++) tick();
        check("age_sweep1_steps", age_n >= base + 9, 1);
        age_model(NE);
        check("age_sweep1_entry", mem[5], ref_entry(5));
        for (int i = 0; i < 300 && age_n < base + 16; i++) tick();
        check("age_sweep2_steps", age_n >= base + 16, 1);
        repeat (3) tick();
        age_en = 1'b0;
        repeat (12) tick();
        mon_age = 1'b0;
        age_model(NE);
        errs = 0;
        for (int i = 0; i < 16; i++) if (int'(age_addr_log[base + i]) != i % NE) errs++;
        check("age_ptr_seq", errs, 0);
        check("age_ptr_wrap", age_addr_log[base + NE], 0);
        check("age_aged_out_cnt", aged_count - ag0, exp_aged);
        check("age_sweep2_entry", mem[5], ref_entry(5));
        do_lookup(3'h5, mac_a);

        // Continuous lookups starve aging; ticks overrun until requests stop
        rd0     = rd_count;
        ov0     = ovr_count;
        nack    = 0;
        lk_hash = 3'h0;
        lk_mac  = mac_a;
        age_en  = 1'b1;
        lk_req  = 1'b1;
        for (int i = 0; i < 200 && nack < 12; i++) begin
            tick();
            if (lk_ack) nack++;
        end
        lk_req = 1'b0;
        check("ovr_acks", nack, 12);
        check("ovr_no_age_rd", rd_count - rd0, 12);
        check("ovr_pulsed", (ovr_count - ov0) > 0, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rd_count - rd0 > 12) seen = 1'b1;
        end
        check("ovr_age_resumes", seen, 1);
        age_en = 1'b0;
        repeat (6) tick();

        check("rd_wr_exclusive", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_table_arbiter.md
# mac_table_arbiter

Sequences all accesses to the single-port MAC forwarding table (2^ADDR_WIDTH entries, hash-indexed) on behalf of three requesters: destination lookup and source learning, both driven from the Ethernet parser's lookup/learn flags and hash, and an internal aging sweep. It owns the RAM port, performs lookup compare, learn read-modify-write and age-bit maintenance, and returns lookup results to output-port lookup. Sits between the parser and the table RAM in the switching pipeline.

## Interface
- ADDR_WIDTH, 10, table index width (matches parser hash)
- PORT_WIDTH, 16, stored source-port field width
- AGE_DIV, 1000000, clk cycles between aging-sweep steps (≥4)
- Entry width EW = 2+48+PORT_WIDTH: {valid, hit, mac[47:0], port}
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- lk_req  in  1  lookup request; held with lk_hash/lk_mac until lk_ack
- lk_hash  in  ADDR_WIDTH  lookup index
- lk_mac  in  48  destination MAC
- lk_ack  out  1  one-cycle pulse, result valid
- lk_hit  out  1  entry valid and MAC matched
- lk_port  out  PORT_WIDTH  stored port on hit, 0 on miss
- ln_req  in  1  learn request; held with ln_hash/ln_mac/ln_port until ln_ack
- ln_hash  in  ADDR_WIDTH  learn index
- ln_mac  in  48  source MAC
- ln_port  in  PORT_WIDTH  ingress port
- ln_ack  out  1  one-cycle pulse, learn complete
- ln_new  out  1  with ln_ack: table written (new, moved or collision overwrite)
- age_en  in  1  enables aging ticks
- aged_out  out  1  one-cycle pulse when sweep invalidates an entry
- age_overrun  out  1  one-cycle pulse when a tick arrives while a step is still pending
- tbl_addr  out  ADDR_WIDTH  RAM address (registered)
- tbl_rd  out  1  RAM read strobe; tbl_rdata valid next cycle
- tbl_wr  out  1  RAM write strobe
- tbl_wdata  out  EW  RAM write data
- tbl_rdata  in  EW  RAM read data

## Operation
- FSM states: IDLE, LK_WAIT, LK_CMP, LN_WAIT, LN_CMP, AG_WAIT, AG_CMP.
- IDLE grant: lk_req beats ln_req, except ln_req wins if last grant was a lookup (no learn starvation); aging step only when neither request is pending.
- Lookup: IDLE→LK_WAIT (tbl_rd=1, addr=lk_hash) →LK_CMP (rdata valid) →IDLE with lk_ack, lk_hit = valid & mac==lk_mac, lk_port. Table not modified.
- Learn: read as above; in LN_CMP, entry valid & mac==ln_mac & port==ln_port & hit=1 → no write, ln_new=0; otherwise write {1,1,ln_mac,ln_port}, ln_new=1. ln_ack on the cycle after LN_CMP, together with the write strobe.
- Aging: prescaler counts 0..AGE_DIV-1 while age_en; wrap sets age_pending (if already set: age_overrun pulse, tick dropped). Step reads entry at sweep pointer; valid&hit → write hit=0; valid&!hit → write valid=0, aged_out; invalid → no write. Pointer increments after each step, wraps 2^ADDR_WIDTH-1→0; age_pending clears.
- Any entry not refreshed by learning is removed within two full sweeps.
- Exactly one of tbl_rd/tbl_wr per cycle at most; never both.

## Timing
- Reset: all outputs 0, state IDLE, prescaler 0, pointer 0, age_pending 0, last-grant = learn. Table contents untouched (RAM wrapper zero-initialises).
- Lookup: req seen in IDLE at cycle N → tbl_rd at N+1 → lk_ack at N+3; new grant possible at N+3.
- Learn: ln_ack (and write, if any) at N+3; same turnaround.
- Requester must drop req the cycle after ack; req still high at the cycle following ack is a new request.
- Learn-then-lookup to same index: the lookup reads post-write data (writes complete before next grant).
- Reset asserted mid-operation: in-flight access abandoned, no ack, no write issued after reset.

## Structure
- Package mac_table_pkg: entry field offsets/widths (VALID_BIT, HIT_BIT, MAC_LSB, PORT_LSB), entry struct/typedef, FSM state encoding.
- One sub-module: mac_age_ticker (prescaler, age_pending, age_overrun, sweep pointer; advanced by a step_done strobe from the FSM).

## Test plan
- Learn hash 0x05, MAC 00:11:22:33:44:55, port 3 into empty table → write {1,1,mac,3}, ln_new=1; lookup same → lk_hit=1, lk_port=3, lk_ack 3 cycles after req.
- Repeat identical learn → no tbl_wr, ln_new=0; learn same MAC with port 7 → write, ln_new=1, later lookup returns 7.
- lk_req and ln_req held simultaneously for 8 transactions → grants alternate lookup/learn, none starved.
- AGE_DIV=4, ADDR_WIDTH=2, one learned entry, no traffic → first sweep clears hit, second sweep invalidates it with single aged_out pulse; pointer wraps 3→0.
- Continuous lookups with AGE_DIV=4 → age_overrun pulses, no aging access issued until requests stop.
- Assert reset during LN_CMP → no ln_ack, no tbl_wr; all outputs 0 afterwards; subsequent lookup succeeds normally.
